// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 single-precision add/subtract, one shift bit per cycle.
// Start/done handshake; denormals flush to zero, truncating rounding.
module fp_addsub_seq #(
    parameter int MAX_ALIGN = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] c,
    output logic        ov
);

    localparam int DW = $clog2(MAX_ALIGN + 1);
    localparam logic [7:0] MAXA = 8'(MAX_ALIGN);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       c_q, c_d;
    logic              ov_q, ov_d;
    logic              sl_q, sl_d;
    logic              ss_q, ss_d;
    logic              inf_q, inf_d;
    logic signed [9:0] e_q, e_d;
    logic [23:0]       ml_q, ml_d;
    logic [23:0]       ms_q, ms_d;
    logic [DW-1:0]     d_q, d_d;
    logic [24:0]       mr_q, mr_d;

    logic [7:0]  ea, eb, diff;
    logic [23:0] ma, mb;
    logic        swap;

    assign ea   = a_q[30:23];
    assign eb   = b_q[30:23];
    assign ma   = (ea == 8'h00) ? 24'h0 : {1'b1, a_q[22:0]};
    assign mb   = (eb == 8'h00) ? 24'h0 : {1'b1, b_q[22:0]};
    assign swap = {eb, mb} > {ea, ma};
    assign diff = swap ? (eb - ea) : (ea - eb);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        ov_d    = ov_q;
        sl_d    = sl_q;
        ss_d    = ss_q;
        inf_d   = inf_q;
        e_d     = e_q;
        ml_d    = ml_q;
        ms_d    = ms_q;
        d_d     = d_q;
        mr_d    = mr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = {b[31] ^ op, b[30:0]};
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sl_d  = swap ? b_q[31] : a_q[31];
                ss_d  = swap ? a_q[31] : b_q[31];
                e_d   = {2'b00, (swap ? eb : ea)};
                ml_d  = swap ? mb : ma;
                ms_d  = swap ? ma : mb;
                d_d   = diff[DW-1:0];
                inf_d = (ea == 8'hFF) || (eb == 8'hFF);
                if (diff >= MAXA) begin
                    ms_d = 24'h0;
                    d_d  = '0;
                end
                if (ma == 24'h0 && mb == 24'h0) begin
                    c_d     = 32'h0;
                    ov_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (d_q != '0) begin
                    ms_d = ms_q >> 1;
                    d_d  = d_q - 1'b1;
                end else begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sl_q == ss_q) begin
                    mr_d = {1'b0, ml_q} + {1'b0, ms_q};
                end else begin
                    mr_d = {1'b0, ml_q} - {1'b0, ms_q};
                end
                state_d = NORM;
            end
            NORM: begin
                if (inf_q) begin
                    c_d     = {sl_q, 8'hFF, 23'h0};
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else if (mr_q == 25'h0) begin
                    c_d     = 32'h0;
                    ov_d    = 1'b0;
                    state_d = DONE;
                end else if (mr_q[24]) begin
                    mr_d = mr_q >> 1;
                    e_d  = e_q + 10'sd1;
                end else if (!mr_q[23]) begin
                    mr_d = mr_q << 1;
                    e_d  = e_q - 10'sd1;
                end else begin
                    // Exponent may have run below 1 during the left shifts.
                    if (e_q >= 10'sd255) begin
                        c_d  = {sl_q, 8'hFF, 23'h0};
                        ov_d = 1'b1;
                    end else if (e_q <= 10'sd0) begin
                        c_d  = 32'h0;
                        ov_d = 1'b0;
                    end else begin
                        c_d  = {sl_q, e_q[7:0], mr_q[22:0]};
                        ov_d = 1'b0;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            c_q     <= 32'h0;
            ov_q    <= 1'b0;
            sl_q    <= 1'b0;
            ss_q    <= 1'b0;
            inf_q   <= 1'b0;
            e_q     <= '0;
            ml_q    <= 24'h0;
            ms_q    <= 24'h0;
            d_q     <= '0;
            mr_q    <= 25'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
            sl_q    <= sl_d;
            ss_q    <= ss_d;
            inf_q   <= inf_d;
            e_q     <= e_d;
            ml_q    <= ml_d;
            ms_q    <= ms_d;
            d_q     <= d_d;
            mr_q    <= mr_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign c    = c_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq with directed vectors.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy, done, ov;
    logic [31:0] c;

    fp_addsub_seq #(.MAX_ALIGN(26)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .c    (c),
        .ov   (ov)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic        ov;
        int          lmax;
        int          t0;
        string       nm;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int passed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int n_push = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int lat;
                e = q.pop_front();
                lat = cyc - e.t0;
                chk({e.nm, "_c"}, c, e.c);
                chk({e.nm, "_ov"}, {31'h0, ov}, {31'h0, e.ov});
                chk({e.nm, "_lat_ok"}, {31'h0, lat <= e.lmax},
                    32'd1);
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ec,
                         input logic eov, input int lmax,
                         input string nm, input bit push);
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) begin
            q.push_back('{ec, eov, lmax, cyc, nm});
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int dc;
        bit ok;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_c", c, 32'h0);
        chk("rst_ov", {31'h0, ov}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1, 32'h42CDE666, 32'h425909A8, 32'h4242C324, 0, 29,
              "sub_same", 1);
        chk("busy_after_start", {31'h0, busy}, 32'd1);
        issue(1, 32'h41700000, 32'h41700000, 32'h0, 0, 54, "cancel_sub", 1);
        issue(0, 32'h41700000, 32'hC1700000, 32'h0, 0, 54, "cancel_add", 1);
        issue(0, 32'h3F800000, 32'h41F00000, 32'h41F80000, 0, 54,
              "add_1_30", 1);
        issue(1, 32'h41F00000, 32'h3F800000, 32'h41E80000, 0, 54,
              "sub_30_1", 1);
        issue(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 54,
              "overflow", 1);
        issue(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 54,
              "one_one", 1);
        issue(0, 32'h4C000000, 32'h3F800000, 32'h4C000000, 0, 54,
              "d25", 1);
        issue(0, 32'h4C800000, 32'h3F800000, 32'h4C800000, 0, 54,
              "d26", 1);
        issue(0, 32'h00000001, 32'h3F800000, 32'h3F800000, 0, 54,
              "denorm", 1);
        issue(0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1, 54,
              "inf_in", 1);
        issue(1, 32'h00800000, 32'h00800001, 32'h0, 0, 54,
              "underflow", 1);

        issue(0, 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 54,
              "hs_first", 1);
        @(negedge clk);
        op    = 1'b0;
        a     = 32'h7F7FFFFF;
        b     = 32'h7F7FFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        a     = 32'h7F7FFFFF;
        b     = 32'h7F7FFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", {31'h0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("start_in_done_idle", {31'h0, busy}, 32'd0);

        issue(0, 32'h4B000000, 32'h3F800000, 32'h0, 0, 54, "aborted", 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_done", {31'h0, done}, 32'd0);
        chk("midrst_c", c, 32'h0);
        chk("midrst_ov", {31'h0, ov}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        issue(0, 32'h4B000000, 32'h3F800000, 32'h4B000001, 0, 54,
              "after_rst", 1);

        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        repeat (60) @(negedge clk);
        chk("done_count", done_cnt, n_push);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
